// File: rtl/cpu16_pkg.sv
// cpu16_pkg: opcodes, controller states, instruction classes and ALU function codes
// shared by the 16-bit control unit and datapath.
package cpu16_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3, OP_SLT = 4'h4,
    OP_LW = 4'h5, OP_SW = 4'h6, OP_BZ = 4'h7, OP_JMP = 4'h8, OP_HLT = 4'hF
  } opcode_e;
  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3, S_L0, S_L1, S_L2, S_S0, S_S1, S_S2, S_J0,
    S_HALT, S_HALT_ILL
  } state_e;
  typedef enum logic [2:0] {IC_ALU, IC_LW, IC_SW, IC_BZ, IC_JMP, IC_HLT, IC_ILL} iclass_e;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_SLT = 3'b111;
endpackage

// File: rtl/ctrl16_decode.sv
// ctrl16_decode: maps an opcode to its instruction class and ALU function.
module ctrl16_decode
  import cpu16_pkg::*;
(
  input  logic [3:0] op,
  output iclass_e    cls,
  output logic [2:0] fn
);
  always_comb begin
    cls = IC_ILL;
    fn = FN_ADD;
    case (op)
      OP_ADD: cls = IC_ALU;
      OP_SUB: begin cls = IC_ALU; fn = FN_SUB; end
      OP_AND: begin cls = IC_ALU; fn = FN_AND; end
      OP_OR:  begin cls = IC_ALU; fn = FN_OR; end
      OP_SLT: begin cls = IC_ALU; fn = FN_SLT; end
      OP_LW:  cls = IC_LW;
      OP_SW:  cls = IC_SW;
      OP_BZ:  cls = IC_BZ;
      OP_JMP: cls = IC_JMP;
      OP_HLT: cls = IC_HLT;
      default: ;
    endcase
  end
endmodule

// File: rtl/ctrl16_fsm.sv
// ctrl16_fsm: Moore multi-cycle fetch/decode/execute controller for the 16-bit datapath.
// Define CTRL_MEM_TIMEOUT_EN to abort memory waits longer than WAIT_MAX cycles.
module ctrl16_fsm
  import cpu16_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        vin, cin, zin, sin,
  input  logic        mem_ready,
  output logic        mem_rd, mem_wr,
  output logic        lmar, lt, lpc, lir, lmdr, ldx, ldy,
  output logic        tt, tpc, tp, t2, tmdr2x, tmdrext,
  output logic        rmdri, rmarx, rdr, wrr,
  output logic [2:0]  pa, wpa,
  output logic [2:0]  fnsel,
  output logic        halted,
  output logic        illegal
);
  state_e state_q, state_d;
  logic [3:0] flags_q, flags_d;
  iclass_e cls;
  logic [2:0] alu_fn, rd, rs, rt;
  logic tmo, unused_bits;
  assign rd = ir[11:9];
  assign rs = ir[8:6];
  assign rt = ir[5:3];
  assign unused_bits = ^{ir[2:0], flags_q[3:2], flags_q[0]};
  ctrl16_decode u_dec (.op(ir[15:12]), .cls(cls), .fn(alu_fn));
`ifdef CTRL_MEM_TIMEOUT_EN
  logic [15:0] wcnt_q, wcnt_d;
  logic waiting;
  always_comb begin
    waiting = (state_q == S_F1) || (state_q == S_L1) || (state_q == S_S2);
    tmo = waiting && !mem_ready && (wcnt_q + 16'd1 == 16'(WAIT_MAX));
    wcnt_d = (waiting && !mem_ready && !tmo) ? wcnt_q + 16'd1 : 16'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) wcnt_q <= 16'd0;
    else wcnt_q <= wcnt_d;
`else
  logic unused_wait;
  assign tmo = 1'b0;
  assign unused_wait = (WAIT_MAX != 0);
`endif
  always_comb begin
    state_d = state_q;
    flags_d = (state_q == S_A2) ? {vin, cin, zin, sin} : flags_q;
    case (state_q)
      S_IDLE: state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = mem_ready ? S_F2 : S_F1;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC:
        case (cls)
          IC_ALU:  state_d = S_A0;
          IC_LW:   state_d = S_L0;
          IC_SW:   state_d = S_S0;
          IC_BZ:   state_d = flags_q[1] ? S_J0 : S_F0;
          IC_JMP:  state_d = S_J0;
          IC_HLT:  state_d = S_HALT;
          default: state_d = S_HALT_ILL;
        endcase
      S_A0:   state_d = S_A1;
      S_A1:   state_d = S_A2;
      S_A2:   state_d = S_A3;
      S_A3:   state_d = S_F0;
      S_L0:   state_d = S_L1;
      S_L1:   state_d = mem_ready ? S_L2 : S_L1;
      S_L2:   state_d = S_F0;
      S_S0:   state_d = S_S1;
      S_S1:   state_d = S_S2;
      S_S2:   state_d = mem_ready ? S_F0 : S_S2;
      S_J0:   state_d = S_F0;
      default: ;
    endcase
    if (tmo) state_d = S_HALT_ILL;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  // Outputs depend only on state, the held IR fields and, in read waits, mem_ready.
  always_comb begin
    {mem_rd, mem_wr, lmar, lt, lpc, lir, lmdr, ldx, ldy} = '0;
    {tt, tpc, tp, t2, tmdr2x, tmdrext, rmdri, rmarx, rdr, wrr} = '0;
    {pa, wpa, fnsel, halted, illegal} = '0;
    case (state_q)
      S_F0: {tpc, lmar, ldx} = '1;
      S_F1: begin
        {t2, ldy, rmarx, mem_rd} = '1;
        lmdr = mem_ready;
        rmdri = mem_ready;
      end
      S_F2: begin {lir, lt} = '1; fnsel = FN_ADD; end
      S_F3: {tt, lpc} = '1;
      S_A0: begin {rdr, tp, ldx} = '1; pa = rs; end
      S_A1: begin {rdr, tp, ldy} = '1; pa = rt; end
      S_A2: begin lt = 1'b1; fnsel = alu_fn; end
      S_A3: begin {tt, wrr} = '1; wpa = rd; end
      S_L0, S_S0: begin {rdr, tp, lmar} = '1; pa = rs; end
      S_L1: begin
        {rmarx, mem_rd} = '1;
        lmdr = mem_ready;
        rmdri = mem_ready;
      end
      S_L2: begin {tmdr2x, wrr} = '1; wpa = rd; end
      S_S1: begin {rdr, tp, lmdr} = '1; pa = rd; end
      S_S2: {rmarx, tmdrext, mem_wr} = '1;
      S_J0: begin {rdr, tp, lpc} = '1; pa = rs; end
      S_HALT: halted = 1'b1;
      S_HALT_ILL: {halted, illegal} = '1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl16_fsm.sv
// tb_ctrl16_fsm: directed per-cycle checks of the full control word for each
// instruction class, wait states, illegal halt and asynchronous reset.
module tb_ctrl16_fsm;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic vin = 1'b0, cin = 1'b0, zin = 1'b0, sin = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic mem_rd, mem_wr, lmar, lt, lpc, lir, lmdr, ldx, ldy;
  logic tt, tpc, tp, t2, tmdr2x, tmdrext, rmdri, rmarx, rdr, wrr;
  logic [2:0] pa, wpa, fnsel;
  logic halted, illegal;
  logic [29:0] obs;
  int tests = 0, fails = 0;

  ctrl16_fsm #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .ir(ir), .vin(vin), .cin(cin), .zin(zin), .sin(sin),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .lmar(lmar), .lt(lt), .lpc(lpc), .lir(lir), .lmdr(lmdr), .ldx(ldx), .ldy(ldy),
    .tt(tt), .tpc(tpc), .tp(tp), .t2(t2), .tmdr2x(tmdr2x), .tmdrext(tmdrext),
    .rmdri(rmdri), .rmarx(rmarx), .rdr(rdr), .wrr(wrr), .pa(pa), .wpa(wpa),
    .fnsel(fnsel), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {mem_rd, mem_wr, lmar, lt, lpc, lir, lmdr, ldx, ldy, tt, tpc, tp, t2,
                tmdr2x, tmdrext, rmdri, rmarx, rdr, wrr, pa, wpa, fnsel, halted, illegal};

  localparam logic [29:0] B_RD = 30'd1 << 29, B_WR = 30'd1 << 28, B_LMAR = 30'd1 << 27;
  localparam logic [29:0] B_LT = 30'd1 << 26, B_LPC = 30'd1 << 25, B_LIR = 30'd1 << 24;
  localparam logic [29:0] B_LMDR = 30'd1 << 23, B_LDX = 30'd1 << 22, B_LDY = 30'd1 << 21;
  localparam logic [29:0] B_TT = 30'd1 << 20, B_TPC = 30'd1 << 19, B_TP = 30'd1 << 18;
  localparam logic [29:0] B_T2 = 30'd1 << 17, B_TMDR2X = 30'd1 << 16, B_TMDREXT = 30'd1 << 15;
  localparam logic [29:0] B_RMDRI = 30'd1 << 14, B_RMARX = 30'd1 << 13, B_RDR = 30'd1 << 12;
  localparam logic [29:0] B_WRR = 30'd1 << 11, B_HALTED = 30'd1 << 1, B_ILLEGAL = 30'd1;
  localparam logic [29:0] W_F0 = B_TPC | B_LMAR | B_LDX;
  localparam logic [29:0] W_F1W = B_T2 | B_LDY | B_RMARX | B_RD;
  localparam logic [29:0] W_F1R = W_F1W | B_LMDR | B_RMDRI;
  localparam logic [29:0] W_F2 = B_LIR | B_LT | 30'd8;
  localparam logic [29:0] W_F3 = B_TT | B_LPC;
  localparam logic [29:0] W_ILL = B_HALTED | B_ILLEGAL;

  function automatic logic [29:0] pa_f(input logic [2:0] a);
    return {19'd0, a, 8'd0};
  endfunction
  function automatic logic [29:0] wpa_f(input logic [2:0] a);
    return {22'd0, a, 5'd0};
  endfunction
  function automatic logic [29:0] fn_f(input logic [2:0] f);
    return {25'd0, f, 2'd0};
  endfunction

  task automatic test_reset();
    if (obs !== 30'd0) begin
      fails++; $display("FAIL reset_word: got %h expected %h", obs, 30'd0);
    end
    tests++;
    rst = 1'b0;
    #1;
    if (obs !== 30'd0) begin
      fails++; $display("FAIL idle_word: got %h expected %h", obs, 30'd0);
    end
    tests++;
    @(negedge clk);
  endtask

  task automatic test_alu(input logic [3:0] op, input logic [2:0] fn, input logic z);
    logic [29:0] e[$];
    ir = {op, 3'd1, 3'd2, 3'd3, 3'd0};
    zin = z;
    mem_ready = 1'b1;
    e = '{W_F0, W_F1R, W_F2, W_F3, 30'd0, B_RDR | B_TP | B_LDX | pa_f(3'd2),
          B_RDR | B_TP | B_LDY | pa_f(3'd3), B_LT | fn_f(fn), B_TT | B_WRR | wpa_f(3'd1)};
    foreach (e[i]) begin
      #1;
      if (obs !== e[i]) begin
        fails++; $display("FAIL alu_op%0h[%0d]: got %h expected %h", op, i, obs, e[i]);
      end
      tests++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [29:0] e[$];
    logic r[$];
    ir = 16'h5940;
    e = '{W_F0, W_F1R, W_F2, W_F3, 30'd0, B_RDR | B_TP | B_LMAR | pa_f(3'd5),
          B_RMARX | B_RD, B_RMARX | B_RD, B_RMARX | B_RD,
          B_RMARX | B_RD | B_LMDR | B_RMDRI, B_TMDR2X | B_WRR | wpa_f(3'd4)};
    r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    foreach (e[i]) begin
      mem_ready = r[i];
      #1;
      if (obs !== e[i]) begin
        fails++; $display("FAIL lw[%0d]: got %h expected %h", i, obs, e[i]);
      end
      tests++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_sw();
    logic [29:0] e[$];
    ir = 16'h6DC0;
    e = '{W_F0, W_F1R, W_F2, W_F3, 30'd0, B_RDR | B_TP | B_LMAR | pa_f(3'd7),
          B_RDR | B_TP | B_LMDR | pa_f(3'd6), B_RMARX | B_TMDREXT | B_WR,
          B_RMARX | B_TMDREXT | B_WR};
    foreach (e[i]) begin
      mem_ready = (i != 7);
      #1;
      if (obs !== e[i]) begin
        fails++; $display("FAIL sw[%0d]: got %h expected %h", i, obs, e[i]);
      end
      tests++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_branch(input logic [3:0] op, input logic [2:0] rs, input logic taken);
    logic [29:0] e[$];
    ir = {op, 3'd0, rs, 6'd0};
    mem_ready = 1'b1;
    e = '{W_F0, W_F1R, W_F2, W_F3, 30'd0};
    if (taken) e.push_back(B_RDR | B_TP | B_LPC | pa_f(rs));
    foreach (e[i]) begin
      #1;
      if (obs !== e[i]) begin
        fails++; $display("FAIL branch_op%0h[%0d]: got %h expected %h", op, i, obs, e[i]);
      end
      tests++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt(input logic [15:0] instr, input logic [29:0] hw, input int hold);
    logic [29:0] e[$];
    ir = instr;
    mem_ready = 1'b1;
    e = '{W_F0, W_F1R, W_F2, W_F3, 30'd0};
    for (int k = 0; k < hold; k++) e.push_back(hw);
    foreach (e[i]) begin
      if (i > 4) mem_ready = i[0];
      #1;
      if (obs !== e[i]) begin
        fails++; $display("FAIL halt_%h[%0d]: got %h expected %h", instr, i, obs, e[i]);
      end
      tests++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    #1;
    if (obs !== 30'd0) begin
      fails++; $display("FAIL rst_from_halt: got %h expected %h", obs, 30'd0);
    end
    tests++;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    if (obs !== W_F0) begin
      fails++; $display("FAIL mr_f0: got %h expected %h", obs, W_F0);
    end
    tests++;
    @(negedge clk);
    #1;
    if (obs !== W_F1W) begin
      fails++; $display("FAIL mr_f1: got %h expected %h", obs, W_F1W);
    end
    tests++;
    #2;
    rst = 1'b1;
    #1;
    if (mem_rd !== 1'b0 || obs !== 30'd0) begin
      fails++; $display("FAIL mr_abort: got mem_rd=%b word=%h expected 0", mem_rd, obs);
    end
    tests++;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (obs !== W_F1W) begin
        fails++; $display("FAIL tmo_wait[%0d]: got %h expected %h", i, obs, W_F1W);
      end
      tests++;
    end
    @(negedge clk);
    #1;
    if (obs !== W_ILL || mem_rd !== 1'b0) begin
      fails++; $display("FAIL tmo_halt: got %h expected %h", obs, W_ILL);
    end
    tests++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_alu(4'h0, 3'b010, 1'b0);
    test_lw();
    test_sw();
    test_branch(4'h7, 3'd2, 1'b0);
    test_alu(4'h1, 3'b110, 1'b1);
    test_branch(4'h7, 3'd5, 1'b1);
    test_branch(4'h8, 3'd3, 1'b1);
    test_alu(4'h2, 3'b000, 1'b0);
    test_alu(4'h3, 3'b001, 1'b0);
    test_alu(4'h4, 3'b111, 1'b0);
    test_branch(4'h7, 3'd4, 1'b0);
    test_halt(16'hB000, W_ILL, 20);
    test_mid_reset();
    test_halt(16'hF000, B_HALTED, 4);
`ifdef CTRL_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
